matmul_tile_engine: RTL
=======================

// Module: matmul_tile_engine
// PURPOSE
//  Parametrised ROWS x COLS matrix-multiply tile engine: C = A(ROWS x K) * B(K x COLS).
//  Operands arrive on AXI-Stream A/B and results leave on AXI-Stream C.
//  Next-generation compute core behind the AXI-Lite control block.
//  Adds real MAC arithmetic, run-time K, TLAST checking, sticky done/error with SW clear, and an IRQ pulse.
// PARAMETERS
//  DATA_W  32  width of every A/B/C element, two's-complement signed
//  ROWS    2   rows of A and C (>=1)
//  COLS    2   columns of B and C (>=1)
//  K_MAX   64  maximum inner dimension accepted by cfg_k
// PORTS
//  clk              in   1                 single clock; all logic rising-edge
//  rst              in   1                 synchronous, active-high reset
//  s_axis_a_tdata   in   DATA_W            A element, row-major (a[0][0], a[0][1], ...)
//  s_axis_a_tvalid  in   1                 A beat valid
//  s_axis_a_tready  out  1                 A beat accepted
//  s_axis_a_tlast   in   1                 marks last A element
//  s_axis_b_tdata   in   DATA_W            B element, row-major (b[0][0], b[0][1], ...)
//  s_axis_b_tvalid / s_axis_b_tready / s_axis_b_tlast    as for A
//  m_axis_c_tdata   out  DATA_W            C element, row-major
//  m_axis_c_tvalid  out  1                 C beat valid
//  m_axis_c_tready  in   1                 downstream ready
//  m_axis_c_tlast   out  1                 asserted on the final C beat only
//  cfg_k            in   16                inner dimension K; sampled when start is accepted
//  start            in   1                 level; accepted only in IDLE
//  done_clr         in   1                 clears done and err
//  done             out  1                 sticky: job complete
//  err              out  1                 sticky: bad cfg_k or TLAST mismatch
//  irq              out  1                 1-cycle pulse, cycle after done or err sets
//  busy             out  1                 1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at clk edge, any state, including mid-job):
//   - state=IDLE; all counters, buffers and C registers cleared.
//   - All outputs 0: tready, tvalid, tlast, tdata, done, err, irq, busy.
//   - A partially transferred job is abandoned; there is no resume.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> OUTPUT -> IDLE.
//   - IDLE: on start, latch K=cfg_k.
//     - If K==0 or K>K_MAX: set err, pulse irq, stay IDLE; no stream beats consumed.
//     - Otherwise go to LOAD_A.
//   - LOAD_A: s_axis_a_tready=1 only in this state.
//     - Accept exactly ROWS*K beats, then go to LOAD_B.
//   - LOAD_B: s_axis_b_tready=1 only in this state.
//     - Accept exactly K*COLS beats, then go to COMPUTE.
//   - TLAST: transitions are count-driven. TLAST does not change state.
//     - TLAST high on a non-final beat, or low on the final beat, sets err (job still completes).
//   - COMPUTE: exactly K cycles; cycle k does acc[i][j] += a[i][k]*b[k][j] for all i,j in parallel.
//     - Accumulators are zeroed on entry.
//   - OUTPUT: emit ROWS*COLS beats, row-major.
//     - Go to IDLE on the handshake of the final beat.
//  Arithmetic: signed product and sum, truncated to DATA_W (wraps modulo 2^DATA_W); no saturation.
//  C handshake:
//   - tvalid/tdata/tlast are registered; tvalid never depends on tready.
//   - While tvalid=1 and tready=0, tdata/tlast hold stable.
//   - tvalid falls only after a handshake; back-to-back beats sustain 1 beat/cycle.
//   - The first C beat is valid the cycle after COMPUTE ends.
//  Done/IRQ:
//   - done sets the cycle after the final C handshake; irq pulses one cycle after that.
//   - done and err hold until done_clr=1.
//   - done_clr in the same cycle as a set event: the set wins.
//   - start while done=1 is accepted (new job; done stays 1 until cleared).
//  start held high after a job: a new job starts immediately from IDLE.
//  Latency (no stalls): 1 + ROWS*K + K*COLS + K cycles from start to first C beat.
// TESTING
//  1. ROWS=COLS=2, K=2, A=[1,2;3,4], B=[5,6;7,8], tready=1
//     -> C=19,22,43,50; tlast on beat 4 only; done=1; irq 1 cycle; err=0.
//  2. Same job, tready toggled 1-0-0-1 per cycle
//     -> 4 beats, data stable during stalls, no dropped/duplicated beats, tvalid never falls unhandshaken.
//  3. start with cfg_k=0, then cfg_k=65
//     -> err=1 and irq pulse each time; tready A/B never asserted; state IDLE; done=0.
//  4. K=3, A TLAST raised on beat 2 of 6
//     -> err=1, all 6 A beats still consumed, correct C produced, done=1.
//  5. rst pulsed mid-LOAD_B, then a fresh K=1 job (A=[2;-3], B=[4,5])
//     -> all outputs 0 after reset; C=8,10,-12,-15.
//  6. K=1, A=[0x7FFFFFFF;0], B=[2,0]
//     -> C[0][0]=0xFFFFFFFE (wrap), others 0; done_clr then clears done on the next cycle.

Source files
------------

// File: rtl/matmul_tile_engine.sv
// ROWS x COLS signed matrix-multiply tile: A and B are streamed in and buffered,
// multiplied over K cycles, and the C tile is streamed out row-major.
//
// state     | meaning
// ----------|--------------------------------------------------
// S_IDLE    | waiting for start; a bad cfg_k raises err here
// S_LOAD_A  | accepting ROWS*K beats of A
// S_LOAD_B  | accepting K*COLS beats of B
// S_COMPUTE | K MAC cycles, one inner index per cycle
// S_OUTPUT  | streaming ROWS*COLS C beats
module matmul_tile_engine #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int K_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic              s_axis_a_tlast,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic              s_axis_b_tlast,
    output logic [DATA_W-1:0] m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    input  logic              m_axis_c_tready,
    output logic              m_axis_c_tlast,
    input  logic [15:0]       cfg_k,
    input  logic              start,
    input  logic              done_clr,
    output logic              done,
    output logic              err,
    output logic              irq,
    output logic              busy
);

    localparam int RI_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CI_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KI_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
    localparam int CNT_W  = $clog2(MAX_RC * K_MAX + ROWS * COLS + 1) + 1;
    localparam logic [CNT_W-1:0] N_OUT = CNT_W'(ROWS * COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] a_mem    [ROWS][K_MAX];
    logic signed [DATA_W-1:0] b_mem    [K_MAX][COLS];
    logic signed [DATA_W-1:0] acc      [ROWS][COLS];
    logic signed [DATA_W-1:0] acc_next [ROWS][COLS];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_cnt;
    logic [KI_W-1:0]  k_last;
    logic [RI_W-1:0]  a_i;
    logic [KI_W-1:0]  a_k;
    logic [KI_W-1:0]  b_k;
    logic [CI_W-1:0]  b_j;
    logic [KI_W-1:0]  comp_k;
    logic [RI_W-1:0]  out_r, nxt_r;
    logic [CI_W-1:0]  out_c, nxt_c;
    logic             set_d;

    logic k_ok, cnt_last, a_fire, b_fire, c_fire;
    logic cfg_err, tlast_err, done_set, err_set;

    assign k_ok     = (cfg_k != 16'd0) && (cfg_k <= 16'(K_MAX));
    assign cnt_last = (cnt == CNT_W'(1));
    assign a_fire   = s_axis_a_tvalid && s_axis_a_tready;
    assign b_fire   = s_axis_b_tvalid && s_axis_b_tready;
    assign c_fire   = m_axis_c_tvalid && m_axis_c_tready;

    assign cfg_err   = (state == S_IDLE) && start && !k_ok;
    assign tlast_err = (a_fire && (s_axis_a_tlast != cnt_last)) ||
                       (b_fire && (s_axis_b_tlast != cnt_last));
    assign err_set   = cfg_err || tlast_err;
    assign done_set  = (state == S_OUTPUT) && c_fire && cnt_last;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && k_ok)         state_nxt = S_LOAD_A;
            S_LOAD_A:  if (a_fire && cnt_last)    state_nxt = S_LOAD_B;
            S_LOAD_B:  if (b_fire && cnt_last)    state_nxt = S_COMPUTE;
            S_COMPUTE: if (cnt_last)              state_nxt = S_OUTPUT;
            S_OUTPUT:  if (c_fire && cnt_last)    state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_a_tready = (state == S_LOAD_A);
        s_axis_b_tready = (state == S_LOAD_B);
        busy            = (state != S_IDLE);
    end

    // Products and sums are taken at DATA_W, so results wrap modulo 2^DATA_W.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                acc_next[i][j] = acc[i][j] + a_mem[i][comp_k] * b_mem[comp_k][j];
            end
        end
    end

    always_comb begin
        nxt_r = out_r;
        nxt_c = out_c + CI_W'(1);
        if (out_c == CI_W'(COLS - 1)) begin
            nxt_c = '0;
            nxt_r = out_r + RI_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int k = 0; k < K_MAX; k++) a_mem[i][k] <= '0;
            for (int k = 0; k < K_MAX; k++)
                for (int j = 0; j < COLS; j++) b_mem[k][j] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
            cnt             <= '0;
            k_cnt           <= '0;
            k_last          <= '0;
            a_i             <= '0;
            a_k             <= '0;
            b_k             <= '0;
            b_j             <= '0;
            comp_k          <= '0;
            out_r           <= '0;
            out_c           <= '0;
            m_axis_c_tdata  <= '0;
            m_axis_c_tvalid <= 1'b0;
            m_axis_c_tlast  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && k_ok) begin
                        k_cnt  <= CNT_W'(cfg_k);
                        k_last <= KI_W'(cfg_k - 16'd1);
                        cnt    <= CNT_W'(ROWS) * CNT_W'(cfg_k);
                        a_i    <= '0;
                        a_k    <= '0;
                        b_k    <= '0;
                        b_j    <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (a_fire) begin
                        a_mem[a_i][a_k] <= s_axis_a_tdata;
                        cnt             <= cnt - CNT_W'(1);
                        if (a_k == k_last) begin
                            a_k <= '0;
                            a_i <= a_i + RI_W'(1);
                        end else begin
                            a_k <= a_k + KI_W'(1);
                        end
                        if (cnt_last) cnt <= CNT_W'(COLS) * k_cnt;
                    end
                end
                S_LOAD_B: begin
                    if (b_fire) begin
                        b_mem[b_k][b_j] <= s_axis_b_tdata;
                        cnt             <= cnt - CNT_W'(1);
                        if (b_j == CI_W'(COLS - 1)) begin
                            b_j <= '0;
                            b_k <= b_k + KI_W'(1);
                        end else begin
                            b_j <= b_j + CI_W'(1);
                        end
                        if (cnt_last) begin
                            cnt    <= k_cnt;
                            comp_k <= '0;
                            for (int i = 0; i < ROWS; i++)
                                for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc    <= acc_next;
                    comp_k <= comp_k + KI_W'(1);
                    cnt    <= cnt - CNT_W'(1);
                    // First C beat is loaded from the final sums, not the stale acc.
                    if (cnt_last) begin
                        cnt             <= N_OUT;
                        out_r           <= '0;
                        out_c           <= '0;
                        m_axis_c_tdata  <= acc_next[0][0];
                        m_axis_c_tvalid <= 1'b1;
                        m_axis_c_tlast  <= (N_OUT == CNT_W'(1));
                    end
                end
                S_OUTPUT: begin
                    if (c_fire) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt_last) begin
                            m_axis_c_tvalid <= 1'b0;
                            m_axis_c_tlast  <= 1'b0;
                            m_axis_c_tdata  <= '0;
                        end else begin
                            out_r           <= nxt_r;
                            out_c           <= nxt_c;
                            m_axis_c_tdata  <= acc[nxt_r][nxt_c];
                            m_axis_c_tlast  <= (cnt == CNT_W'(2));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Set events win over a simultaneous done_clr; irq trails the set by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            err   <= 1'b0;
            set_d <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
            if (err_set)       err  <= 1'b1;
            else if (done_clr) err  <= 1'b0;
            set_d <= done_set || err_set;
            irq   <= set_d;
        end
    end

endmodule
